regfile_wb_arbiter: RTL and testbench

Write-back arbiter for the 32-entry register file. It shares the register file's single write port between two producers: the ALU write-back (requester A) and the load/memory write-back (requester M). Each producer has a one-entry holding slot. The arbiter preserves write order by age and drops writes to `$0`. It also exports a pending-write scoreboard that hazard logic uses for stall decisions.

---
 rtl/regfile_wb_arbiter.sv | 127 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Two-slot write-back arbiter: ALU (A) and load (M) share one register-file write port, oldest first.
// Latency 1 cycle from accept to write when uncontended. Ready is driven only by slot state, never by a Valid input.
// Optional build macro REGFILE_WB_ARB_ROUND_ROBIN_EN alternates same-edge tie winners; when it is undefined, M always wins ties.
module regfile_wb_arbiter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         A_Valid_i,
    input  logic [4:0]   A_Rd_i,
    input  logic [N-1:0] A_Data_i,
    output logic         A_Ready_o,
    input  logic         M_Valid_i,
    input  logic [4:0]   M_Rd_i,
    input  logic [N-1:0] M_Data_i,
    output logic         M_Ready_o,
    output logic         Reg_Write_o,
    output logic [4:0]   Write_Register_o,
    output logic [N-1:0] Write_Data_o,
    output logic [31:0]  Pending_o
);

    logic         a_vld_q, a_vld_d, m_vld_q, m_vld_d;
    logic [4:0]   a_rd_q, a_rd_d, m_rd_q, m_rd_d;
    logic [N-1:0] a_dat_q, a_dat_d, m_dat_q, m_dat_d;
    logic         m_older_q, m_older_d;
    logic         grant_a, grant_m;
    logic         a_load, m_load, a_keep, m_keep, tie, m_wins_tie;

`ifdef REGFILE_WB_ARB_ROUND_ROBIN_EN
    logic tie_a_q, tie_a_d;

    // tie_a_q set means the next same-edge tie goes to A.
    assign m_wins_tie = !tie_a_q;
    assign tie_a_d    = tie ? !tie_a_q : tie_a_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            tie_a_q <= 1'b0;
        end else begin
            tie_a_q <= tie_a_d;
        end
    end
`else
    assign m_wins_tie = 1'b1;
`endif

    always_comb begin
        grant_a = 1'b0;
        grant_m = 1'b0;
        if (!reset) begin
            if (a_vld_q && m_vld_q) begin
                grant_m = m_older_q;
                grant_a = !m_older_q;
            end else begin
                grant_a = a_vld_q;
                grant_m = m_vld_q;
            end
        end

        A_Ready_o = !reset && (!a_vld_q || grant_a);
        M_Ready_o = !reset && (!m_vld_q || grant_m);

        a_load = A_Valid_i && A_Ready_o && (A_Rd_i != 5'd0);
        m_load = M_Valid_i && M_Ready_o && (M_Rd_i != 5'd0);
        a_keep = a_vld_q && !grant_a;
        m_keep = m_vld_q && !grant_m;
        // A loading slot was empty or just granted, so both loading means neither is older.
        tie    = a_load && m_load;

        a_vld_d = a_load || a_keep;
        m_vld_d = m_load || m_keep;
        a_rd_d  = a_load ? A_Rd_i   : a_rd_q;
        a_dat_d = a_load ? A_Data_i : a_dat_q;
        m_rd_d  = m_load ? M_Rd_i   : m_rd_q;
        m_dat_d = m_load ? M_Data_i : m_dat_q;

        if (m_keep) begin
            m_older_d = 1'b1;
        end else if (a_keep) begin
            m_older_d = 1'b0;
        end else begin
            m_older_d = tie && m_wins_tie;
        end
    end

    always_comb begin
        Reg_Write_o      = grant_a || grant_m;
        Write_Register_o = 5'd0;
        Write_Data_o     = '0;
        if (grant_a) begin
            Write_Register_o = a_rd_q;
            Write_Data_o     = a_dat_q;
        end else if (grant_m) begin
            Write_Register_o = m_rd_q;
            Write_Data_o     = m_dat_q;
        end

        Pending_o = 32'd0;
        if (!reset) begin
            if (a_vld_q) Pending_o[a_rd_q] = 1'b1;
            if (m_vld_q) Pending_o[m_rd_q] = 1'b1;
        end
        Pending_o[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_vld_q   <= 1'b0;
            a_rd_q    <= 5'd0;
            a_dat_q   <= '0;
            m_vld_q   <= 1'b0;
            m_rd_q    <= 5'd0;
            m_dat_q   <= '0;
            m_older_q <= 1'b0;
        end else begin
            a_vld_q   <= a_vld_d;
            a_rd_q    <= a_rd_d;
            a_dat_q   <= a_dat_d;
            m_vld_q   <= m_vld_d;
            m_rd_q    <= m_rd_d;
            m_dat_q   <= m_dat_d;
            m_older_q <= m_older_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed plan steps then random traffic against an age-ordered queue model.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        A_Valid_i, M_Valid_i;
    logic [4:0]  A_Rd_i, M_Rd_i;
    logic [31:0] A_Data_i, M_Data_i;
    logic        A_Ready_o, M_Ready_o;
    logic        Reg_Write_o;
    logic [4:0]  Write_Register_o;
    logic [31:0] Write_Data_o;
    logic [31:0] Pending_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        src_m;
        logic [4:0]  rd;
        logic [31:0] dat;
    } ent_t;

    ent_t        q[$];
    int          ties = 0;
    logic [31:0] dut_rf [32];

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.N(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .A_Valid_i        (A_Valid_i),
        .A_Rd_i           (A_Rd_i),
        .A_Data_i         (A_Data_i),
        .A_Ready_o        (A_Ready_o),
        .M_Valid_i        (M_Valid_i),
        .M_Rd_i           (M_Rd_i),
        .M_Data_i         (M_Data_i),
        .M_Ready_o        (M_Ready_o),
        .Reg_Write_o      (Reg_Write_o),
        .Write_Register_o (Write_Register_o),
        .Write_Data_o     (Write_Data_o),
        .Pending_o        (Pending_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check outputs on the falling edge, advance the model on the rising edge.
    task automatic cycle(input logic rst,
                         input logic av, input logic [4:0] ard, input logic [31:0] adat,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] mdat);
        logic        a_in, m_in, e_ra, e_rm, e_wr, a_push, m_push, m_first;
        logic [4:0]  e_rd;
        logic [31:0] e_dat, e_pend;
        ent_t        ea, em;
        reset = rst;
        A_Valid_i = av; A_Rd_i = ard; A_Data_i = adat;
        M_Valid_i = mv; M_Rd_i = mrd; M_Data_i = mdat;

        a_in = 1'b0; m_in = 1'b0; e_pend = 32'd0;
        foreach (q[i]) begin
            if (q[i].src_m) m_in = 1'b1; else a_in = 1'b1;
            e_pend = e_pend | (32'd1 << q[i].rd);
        end
        e_wr  = !rst && (q.size() > 0);
        e_rd  = e_wr ? q[0].rd  : 5'd0;
        e_dat = e_wr ? q[0].dat : 32'd0;
        e_ra  = !rst && (!a_in || q[0].src_m == 1'b0);
        e_rm  = !rst && (!m_in || q[0].src_m == 1'b1);
        if (rst) e_pend = 32'd0;

        @(negedge clk);
        chk("a_ready",   A_Ready_o, e_ra);
        chk("m_ready",   M_Ready_o, e_rm);
        chk("reg_write", Reg_Write_o, e_wr);
        chk("write_rd",  Write_Register_o, e_rd);
        chk("write_dat", Write_Data_o, e_dat);
        chk("pending",   Pending_o, e_pend);
        if (Reg_Write_o === 1'b1) dut_rf[Write_Register_o] = Write_Data_o;

        @(posedge clk);
        if (rst) begin
            q.delete();
            ties = 0;
        end else begin
            if (e_wr) void'(q.pop_front());
            a_push = av && e_ra && (ard != 5'd0);
            m_push = mv && e_rm && (mrd != 5'd0);
            ea = '{src_m: 1'b0, rd: ard, dat: adat};
            em = '{src_m: 1'b1, rd: mrd, dat: mdat};
            if (a_push && m_push) begin
`ifdef REGFILE_WB_ARB_ROUND_ROBIN_EN
                m_first = (ties % 2) == 0;
`else
                m_first = 1'b1;
`endif
                ties++;
                if (m_first) begin q.push_back(em); q.push_back(ea); end
                else         begin q.push_back(ea); q.push_back(em); end
            end else if (a_push) begin
                q.push_back(ea);
            end else if (m_push) begin
                q.push_back(em);
            end
        end
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        logic [31:0] exp_rep;
        foreach (dut_rf[i]) dut_rf[i] = 32'd0;
        reset = 1'b1;
        A_Valid_i = 1'b0; A_Rd_i = 5'd0; A_Data_i = 32'd0;
        M_Valid_i = 1'b0; M_Rd_i = 5'd0; M_Data_i = 32'd0;

        // Reset held two cycles with both requesters asserting.
        cycle(1'b1, 1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
        cycle(1'b1, 1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
        idle();

        // Single write.
        cycle(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        chk("single_we",   Reg_Write_o, 1'b1);
        chk("single_rd",   Write_Register_o, 5'd5);
        chk("single_dat",  Write_Data_o, 32'hDEADBEEF);
        chk("single_pend", Pending_o, 32'h20);
        idle();
        chk("single_pend_clear", Pending_o, 32'h0);

        // First tie after reset goes to M; then age ordering on rd 7.
        cycle(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
        chk("tie_first", Write_Data_o, 32'h22);
        chk("tie_pend1", Pending_o[3], 1'b1);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hAA);
        chk("tie_second", Write_Data_o, 32'h11);
        chk("tie_pend2",  Pending_o[3], 1'b1);
        cycle(1'b0, 1'b1, 5'd7, 32'hBB, 1'b0, 5'd0, 32'd0);
        chk("age_aa", Write_Data_o, 32'hAA);
        chk("tie_pend_clear", Pending_o[3], 1'b0);
        idle();
        chk("age_bb", Write_Data_o, 32'hBB);
        idle();
        chk("rf7_final", dut_rf[7], 32'hBB);
        chk("rf3_final", dut_rf[3], 32'h11);

        // Repeat tie.
        cycle(1'b0, 1'b1, 5'd4, 32'h33, 1'b1, 5'd4, 32'h44);
`ifdef REGFILE_WB_ARB_ROUND_ROBIN_EN
        exp_rep = 32'h33;
`else
        exp_rep = 32'h44;
`endif
        chk("tie_repeat", Write_Data_o, exp_rep);
        idle();
        idle();

        // Write to $0 completes the handshake but is never issued.
        cycle(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0);
        chk("zero_we",   Reg_Write_o, 1'b0);
        chk("zero_pend", Pending_o, 32'h0);

        // Back-to-back ALU writes without a bubble.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 5'(i + 1), 32'h100 + 32'(i), 1'b0, 5'd0, 32'd0);
            chk("b2b_we", Reg_Write_o, 1'b1);
            chk("b2b_rd", Write_Register_o, 5'(i + 1));
        end
        idle();

        // Load both slots, then reset discards them.
        cycle(1'b0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hA0);
        chk("mid_pend", Pending_o, 32'h600);
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("mid_rst_we",   Reg_Write_o, 1'b0);
        chk("mid_rst_pend", Pending_o, 32'h0);
        idle();

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            cycle($urandom_range(0, 49) == 0,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
        end
        for (int n = 0; n < 3; n++) idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
